// File: rtl/layer_pkg.sv
// Shared definitions for the multi-lane layer engine: FSM state codes, width helpers and the
// shift-then-saturate requantiser used by every MAC lane.
package layer_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned vl);
        return 2 * dw + clog2(vl);
    endfunction

    // Operates on a 64-bit sign-extended accumulator; callers truncate to out_w bits.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input logic [4:0] shift,
                                                     input int unsigned out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_buffer.sv
// Simple dual-port synchronous RAM: one write port, one read port with 1-cycle read latency.
// Contents are never reset.
module bram_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mac_lane.sv
// One MAC lane: full-precision signed accumulator with clear/enable, plus the requantised
// (shift, saturate, optional clamp-to-zero) result.
module mac_lane
    import layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 36,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] tok,
    input  logic [DATA_WIDTH-1:0] wgt,
    input  logic [4:0]            shift,
    input  logic                  relu,
    output logic [OUT_WIDTH-1:0]  res
);

    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [OUT_WIDTH-1:0]    sat;

    assign prod = $signed(tok) * $signed(wgt);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_WIDTH'(prod);
        end
    end

    assign sat = OUT_WIDTH'(sat_shift(64'(acc_q), shift, OUT_WIDTH));
    assign res = (relu && sat[OUT_WIDTH-1]) ? '0 : sat;

endmodule

// File: rtl/layer_engine_mc.sv
// Multi-lane linear-layer engine: token, banked weight and result memories feeding NUM_LANES
// MAC lanes. Define LAYER_RELU_EN to add the cfg_relu port and clamp-negatives-to-zero option.
module layer_engine_mc
    import layer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned VECTOR_LEN  = 16,
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned OUT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
`ifdef LAYER_RELU_EN
    input  logic                  cfg_relu,
`endif
    input  logic                  token_wr_en,
    input  logic [ADDR_WIDTH-1:0] token_wr_addr,
    input  logic [DATA_WIDTH-1:0] token_wr_data,
    input  logic                  weight_wr_en,
    input  logic [ADDR_WIDTH-1:0] weight_wr_addr,
    input  logic [DATA_WIDTH-1:0] weight_wr_data,
    input  logic                  result_rd_en,
    input  logic [ADDR_WIDTH-1:0] result_rd_addr,
    output logic [OUT_WIDTH-1:0]  result_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_conflict
);

    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, VECTOR_LEN);
    localparam int unsigned NUM_GROUPS = NUM_NEURONS / NUM_LANES;
    localparam int unsigned K_BITS = clog2(VECTOR_LEN);
    localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? clog2(NUM_LANES) : 1;
    localparam int unsigned G_BITS = (NUM_GROUPS > 1) ? clog2(NUM_GROUPS) : 1;
    localparam int unsigned BANK_AW = ADDR_WIDTH - LANE_BITS;

    logic [2:0]           state_q, state_d;
    logic [K_BITS-1:0]    k_q;
    logic [G_BITS-1:0]    g_q;
    logic [LANE_BITS-1:0] l_q;
    logic                 rd_vld_q;
    logic [4:0]           shift_q;
    logic                 relu_q;
    logic                 conflict_q;

    logic                 k_last, l_last, g_last, accept, lane_clr;
    logic [DATA_WIDTH-1:0] tok_rd;
    logic [DATA_WIDTH-1:0] wgt_rd [NUM_LANES];
    logic [OUT_WIDTH-1:0]  lane_res [NUM_LANES];
    logic [BANK_AW-1:0]    bank_rd_addr;
    logic [LANE_BITS-1:0]  wr_lane;
    logic [BANK_AW-1:0]    wr_local;
    logic [ADDR_WIDTH-1:0] res_wr_addr;

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign wr_conflict = conflict_q;
    assign accept      = (state_q == StIdle) && start;
    assign k_last      = (k_q == K_BITS'(VECTOR_LEN - 1));
    assign l_last      = (l_q == LANE_BITS'(NUM_LANES - 1));
    assign g_last      = (g_q == G_BITS'(NUM_GROUPS - 1));
    assign lane_clr    = (state_d == StFetch) && (state_q != StFetch);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (k_last) state_d = StDrain;
            StDrain: state_d = StWrite;
            StWrite: if (l_last) state_d = g_last ? StDone : StFetch;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            g_q        <= '0;
            l_q        <= '0;
            rd_vld_q   <= 1'b0;
            shift_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= (state_q == StFetch);
            case (state_q)
                StIdle: begin
                    k_q <= '0;
                    g_q <= '0;
                    l_q <= '0;
                    if (start) shift_q <= cfg_shift;
                end
                StFetch: k_q <= k_q + 1'b1;
                StDrain: l_q <= '0;
                StWrite: begin
                    l_q <= l_q + 1'b1;
                    if (l_last) begin
                        g_q <= g_q + 1'b1;
                        k_q <= '0;
                    end
                end
                default: ;
            endcase
            if (busy && (token_wr_en || weight_wr_en)) begin
                conflict_q <= 1'b1;
            end else if (accept) begin
                conflict_q <= 1'b0;
            end
        end
    end

`ifdef LAYER_RELU_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_q <= 1'b0;
        end else if (accept) begin
            relu_q <= cfg_relu;
        end
    end
`else
    assign relu_q = 1'b0;
`endif

    // Weight address n*VECTOR_LEN+k: lane from the low neuron bits, bank row from the rest.
    assign wr_lane  = weight_wr_addr[K_BITS +: LANE_BITS];
    assign wr_local = {weight_wr_addr[ADDR_WIDTH-1 -: ADDR_WIDTH-K_BITS-LANE_BITS],
                       weight_wr_addr[K_BITS-1:0]};
    assign bank_rd_addr = BANK_AW'(g_q) * BANK_AW'(VECTOR_LEN) + BANK_AW'(k_q);
    assign res_wr_addr  = ADDR_WIDTH'(g_q) * ADDR_WIDTH'(NUM_LANES) + ADDR_WIDTH'(l_q);

    bram_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_token_mem (
        .clk     (clk),
        .wr_en   (token_wr_en && !busy),
        .wr_addr (token_wr_addr),
        .wr_data (token_wr_data),
        .rd_en   (state_q == StFetch),
        .rd_addr (ADDR_WIDTH'(k_q)),
        .rd_data (tok_rd)
    );

    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        bram_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BANK_AW)
        ) u_weight_bank (
            .clk     (clk),
            .wr_en   (weight_wr_en && !busy && (wr_lane == LANE_BITS'(b))),
            .wr_addr (wr_local),
            .wr_data (weight_wr_data),
            .rd_en   (state_q == StFetch),
            .rd_addr (bank_rd_addr),
            .rd_data (wgt_rd[b])
        );

        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH)
        ) u_mac (
            .clk   (clk),
            .rst   (rst),
            .clr   (lane_clr),
            .en    (rd_vld_q),
            .tok   (tok_rd),
            .wgt   (wgt_rd[b]),
            .shift (shift_q),
            .relu  (relu_q),
            .res   (lane_res[b])
        );
    end

    bram_buffer #(
        .DATA_WIDTH (OUT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_result_mem (
        .clk     (clk),
        .wr_en   (state_q == StWrite),
        .wr_addr (res_wr_addr),
        .wr_data (lane_res[l_q]),
        .rd_en   (result_rd_en),
        .rd_addr (result_rd_addr),
        .rd_data (result_rd_data)
    );

endmodule

// File: tb/tb_layer_engine_mc.sv
// Self-checking bench for layer_engine_mc: directed cases plus randomized vectors checked
// against a dot-product/requant reference model. Honours LAYER_RELU_EN when defined.
module tb_layer_engine_mc;

    localparam int VL = 16;
    localparam int NN = 8;
    localparam logic signed [63:0] MAXV = 64'sd2147483647;
    localparam logic signed [63:0] MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_shift;
`ifdef LAYER_RELU_EN
    logic        cfg_relu;
`endif
    logic        token_wr_en;
    logic [9:0]  token_wr_addr;
    logic [15:0] token_wr_data;
    logic        weight_wr_en;
    logic [9:0]  weight_wr_addr;
    logic [15:0] weight_wr_data;
    logic        result_rd_en;
    logic [9:0]  result_rd_addr;
    logic [31:0] result_rd_data;
    logic        busy;
    logic        done;
    logic        wr_conflict;

    int total = 0;
    int bad = 0;

    shortint tok_m [VL];
    shortint wgt_m [NN][VL];

    always #5 clk = ~clk;

    layer_engine_mc u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_shift      (cfg_shift),
`ifdef LAYER_RELU_EN
        .cfg_relu       (cfg_relu),
`endif
        .token_wr_en    (token_wr_en),
        .token_wr_addr  (token_wr_addr),
        .token_wr_data  (token_wr_data),
        .weight_wr_en   (weight_wr_en),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_data (weight_wr_data),
        .result_rd_en   (result_rd_en),
        .result_rd_addr (result_rd_addr),
        .result_rd_data (result_rd_data),
        .busy           (busy),
        .done           (done),
        .wr_conflict    (wr_conflict)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] model(input int n, input int sh, input bit rl);
        logic signed [63:0] acc;
        logic signed [63:0] r;
        acc = 0;
        for (int k = 0; k < VL; k++) acc += 64'(tok_m[k]) * 64'(wgt_m[n][k]);
        r = acc >>> sh;
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
        if (rl && r < 0) r = 0;
        return r;
    endfunction

    task automatic load_all();
        for (int k = 0; k < VL; k++) begin
            @(negedge clk);
            token_wr_en = 1'b1; token_wr_addr = 10'(k); token_wr_data = tok_m[k];
        end
        @(negedge clk);
        token_wr_en = 1'b0;
        for (int n = 0; n < NN; n++) begin
            for (int k = 0; k < VL; k++) begin
                @(negedge clk);
                weight_wr_en = 1'b1; weight_wr_addr = 10'(n * VL + k);
                weight_wr_data = wgt_m[n][k];
            end
        end
        @(negedge clk);
        weight_wr_en = 1'b0;
    endtask

    task automatic check_results(input string tag, input int sh, input bit rl);
        for (int n = 0; n < NN; n++) begin
            @(negedge clk);
            result_rd_en = 1'b1; result_rd_addr = 10'(n);
            @(negedge clk);
            result_rd_en = 1'b0;
            check($sformatf("%s.res%0d", tag, n), 64'($signed(result_rd_data)), model(n, sh, rl));
        end
    endtask

    // Start on the next edge (that edge is edge 1), then observe 60 edges; c counts edges seen.
    task automatic run(input int sh, input bit rl, input int again_at, input int twr_at,
                       input int rst_at, input bit sim_wr, input int sim_k,
                       output int done_at, output int busy_cyc, output int done_cnt);
        done_at = 0; busy_cyc = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; cfg_shift = 5'(sh);
`ifdef LAYER_RELU_EN
        cfg_relu = rl;
`endif
        if (sim_wr) begin
            token_wr_en = 1'b1; token_wr_addr = 10'(sim_k); token_wr_data = tok_m[sim_k];
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0; token_wr_en = 1'b0; rst = 1'b0;
            if (c == 1) begin
                check("start.busy", 64'(busy), 64'd1);
                check("start.conflict_clr", 64'(wr_conflict), 64'd0);
            end
            if (rst_at != 0 && c == rst_at + 1) begin
                check("rst.busy", 64'(busy), 64'd0);
                check("rst.done", 64'(done), 64'd0);
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end else if (busy) begin
                busy_cyc++;
            end
            if (c == again_at) start = 1'b1;
            if (c == twr_at) begin
                token_wr_en = 1'b1; token_wr_addr = 10'd0; token_wr_data = 16'h7777;
            end
            if (c == rst_at) rst = 1'b1;
        end
    endtask

    int da, bc, dc;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_shift = '0;
`ifdef LAYER_RELU_EN
        cfg_relu = 1'b0;
`endif
        token_wr_en = 1'b0; token_wr_addr = '0; token_wr_data = '0;
        weight_wr_en = 1'b0; weight_wr_addr = '0; weight_wr_data = '0;
        result_rd_en = 1'b0; result_rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.conflict", 64'(wr_conflict), 64'd0);
        rst = 1'b0;

        // Ones times (n+1): timing and basic results
        for (int k = 0; k < VL; k++) tok_m[k] = 16'sd1;
        for (int n = 0; n < NN; n++) for (int k = 0; k < VL; k++) wgt_m[n][k] = shortint'(n + 1);
        load_all();
        run(0, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check("t1.done_at", 64'(da), 64'd43);
        check("t1.busy_cycles", 64'(bc), 64'd42);
        check("t1.done_count", 64'(dc), 64'd1);
        check("t1.idle_busy", 64'(busy), 64'd0);
        check_results("t1", 0, 1'b0);
        check("t1.res7_literal", model(7, 0, 1'b0), 64'd128);

        // Second start ignored; write while busy dropped and flagged
        run(0, 1'b0, 5, 10, 0, 1'b0, 0, da, bc, dc);
        check("t4.done_at", 64'(da), 64'd43);
        check("t4.done_count", 64'(dc), 64'd1);
        check("t4.conflict", 64'(wr_conflict), 64'd1);
        check_results("t4", 0, 1'b0);

        // Reset mid-run then a clean rerun
        run(0, 1'b0, 0, 0, 10, 1'b0, 0, da, bc, dc);
        check("t5.done_count", 64'(dc), 64'd0);
        run(0, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check("t5.done_at", 64'(da), 64'd43);
        check_results("t5", 0, 1'b0);

        // Saturation both ways
        for (int k = 0; k < VL; k++) tok_m[k] = 16'sd32767;
        for (int n = 0; n < NN; n++) for (int k = 0; k < VL; k++) wgt_m[n][k] = 16'sd32767;
        load_all();
        run(0, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check_results("t2pos", 0, 1'b0);
        for (int n = 0; n < NN; n++) for (int k = 0; k < VL; k++) wgt_m[n][k] = -16'sd32768;
        load_all();
        run(0, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check_results("t2neg", 0, 1'b0);

        // Sign and shift
        for (int k = 0; k < VL; k++) tok_m[k] = 16'sd4;
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < VL; k++) wgt_m[n][k] = (n % 2 == 0) ? 16'sd3 : -16'sd3;
        load_all();
        run(2, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check_results("t3", 2, 1'b0);
`ifdef LAYER_RELU_EN
        run(2, 1'b1, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check_results("t6relu", 2, 1'b1);
        run(2, 1'b0, 0, 0, 0, 1'b0, 0, da, bc, dc);
        check_results("t6norelu", 2, 1'b0);
`endif

        // Randomized vectors; a token write coincides with each start
        for (int it = 0; it < 4; it++) begin
            int sh;
            int sk;
            bit rl;
            for (int k = 0; k < VL; k++)
                tok_m[k] = (it % 2 == 0) ? shortint'($urandom) : shortint'($urandom_range(0, 511) - 256);
            for (int n = 0; n < NN; n++)
                for (int k = 0; k < VL; k++)
                    wgt_m[n][k] = (it % 2 == 0) ? shortint'($urandom)
                                                : shortint'($urandom_range(0, 511) - 256);
            sh = (it % 2 == 0) ? int'($urandom_range(3, 31)) : int'($urandom_range(0, 4));
`ifdef LAYER_RELU_EN
            rl = 1'($urandom);
`else
            rl = 1'b0;
`endif
            load_all();
            sk = int'($urandom_range(0, VL - 1));
            tok_m[sk] = shortint'($urandom);
            run(sh, rl, 0, 0, 0, 1'b1, sk, da, bc, dc);
            check($sformatf("rnd%0d.done_at", it), 64'(da), 64'd43);
            check_results($sformatf("rnd%0d", it), sh, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
